pll_bringup_seq: RTL

Power-up sequencer between the SPI configuration receiver and the PLL map core. It captures each 512-bit PLL configuration word on the receive-done pulse and replays it to the map core in a safe order: LDO on with the PLL held off, LDO settle, then PLL enable. It then supervises the PLL `lock` output and reports locked or timeout status. On timeout it powers the PLL back down.

---
 rtl/pll_bringup_seq.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_bringup_seq.sv
// PLL power-up sequencer: replays each captured config word as LDO-on, settle, PLL-on, then supervises lock.
// Optional build macro PLL_SEQ_RETRY_EN: a failed lock attempt is retried up to 3 times before timeout_o is raised.
module pll_bringup_seq #(
   parameter int DATA_WIDTH       = 512,
   parameter int LDO_EN_BIT       = 1,
   parameter int PLLEN_BIT        = 2,
   parameter int SETTLE_CYC       = 64,
   parameter int LOCK_TIMEOUT_CYC = 4096,
   parameter int LOCK_STABLE_CYC  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_valid_i,
   input  logic [DATA_WIDTH-1:0] cfg_data_i,
   input  logic                  lock_i,
   output logic                  cfg_valid_o,
   output logic [DATA_WIDTH-1:0] cfg_data_o,
   output logic                  busy_o,
   output logic                  locked_o,
   output logic                  timeout_o,
   output logic [2:0]            state_o
);

   // Handshake: cfg_valid_i and cfg_valid_o are single-cycle pulses with no ready/backpressure;
   // data is sampled only in the pulse cycle, and cfg_data_o holds its value between pulses.

   localparam int MAX_AB = (SETTLE_CYC > LOCK_TIMEOUT_CYC) ? SETTLE_CYC : LOCK_TIMEOUT_CYC;
   localparam int MAX_C  = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
   localparam int CW     = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] TIMEOUT_LIM = CW'(LOCK_TIMEOUT_CYC);
   localparam logic [CW-1:0] STABLE_LIM  = CW'(LOCK_STABLE_CYC);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DIRECT    = 3'd1;
   localparam logic [2:0] ST_APPLY0    = 3'd2;
   localparam logic [2:0] ST_SETTLE    = 3'd3;
   localparam logic [2:0] ST_APPLY1    = 3'd4;
   localparam logic [2:0] ST_LOCK_WAIT = 3'd5;
   localparam logic [2:0] ST_LOCKED    = 3'd6;
   localparam logic [2:0] ST_FAIL      = 3'd7;

   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         stab_q, stab_d, stab_inc;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  locked_q, locked_d;
   logic                  timeout_q, timeout_d;
   logic                  lock_meta_q, lock_s_q;
   logic [DATA_WIDTH-1:0] word_a0, word_off;
`ifdef PLL_SEQ_RETRY_EN
   logic [1:0]            retry_q, retry_d;
`endif

   assign shadow_d = cfg_valid_i ? cfg_data_i : shadow_q;

   always_comb begin
      word_a0             = shadow_d;
      word_a0[LDO_EN_BIT] = 1'b1;
      word_a0[PLLEN_BIT]  = 1'b0;
      word_off            = shadow_d;
      word_off[PLLEN_BIT] = 1'b0;
   end

   assign stab_inc = (stab_q == CNT_MAX) ? stab_q : stab_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stab_d    = stab_q;
      valid_d   = 1'b0;
      data_d    = data_q;
      timeout_d = timeout_q;
`ifdef PLL_SEQ_RETRY_EN
      retry_d   = retry_q;
`endif
      // A new word in any state restarts the sequence and replaces any pulse due this cycle.
      if (cfg_valid_i) begin
         timeout_d = 1'b0;
         cnt_d     = '0;
         stab_d    = '0;
         valid_d   = 1'b1;
`ifdef PLL_SEQ_RETRY_EN
         retry_d   = 2'd0;
`endif
         if (cfg_data_i[PLLEN_BIT]) begin
            state_d = ST_APPLY0;
            data_d  = word_a0;
         end else begin
            state_d = ST_DIRECT;
            data_d  = cfg_data_i;
         end
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_DIRECT: state_d = ST_IDLE;
            ST_APPLY0: begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end
            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = ST_APPLY1;
                  valid_d = 1'b1;
                  data_d  = shadow_q;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_APPLY1: begin
               state_d = ST_LOCK_WAIT;
               cnt_d   = '0;
               stab_d  = '0;
            end
            ST_LOCK_WAIT: begin
               stab_d = lock_s_q ? stab_inc : '0;
               // Lock is tested first so it wins a tie with the timeout.
               if (stab_d >= STABLE_LIM) begin
                  state_d = ST_LOCKED;
`ifdef PLL_SEQ_RETRY_EN
                  retry_d = 2'd0;
`endif
               end else if (cnt_q >= TIMEOUT_LIM) begin
                  state_d = ST_FAIL;
                  valid_d = 1'b1;
                  data_d  = word_off;
`ifdef PLL_SEQ_RETRY_EN
                  timeout_d = (retry_q == 2'd3);
`else
                  timeout_d = 1'b1;
`endif
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_LOCKED: ;
            ST_FAIL: begin
`ifdef PLL_SEQ_RETRY_EN
               if (retry_q != 2'd3) begin
                  retry_d = retry_q + 2'd1;
                  state_d = ST_APPLY0;
                  valid_d = 1'b1;
                  data_d  = word_a0;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign busy_d   = (state_d != ST_IDLE) && (state_d != ST_LOCKED);
   // lock_meta_q is next cycle's lock_s, so locked_o tracks lock_s in the same cycle.
   assign locked_d = (state_d == ST_LOCKED) && lock_meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         cnt_q       <= '0;
         stab_q      <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         locked_q    <= 1'b0;
         timeout_q   <= 1'b0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         cnt_q       <= cnt_d;
         stab_q      <= stab_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         locked_q    <= locked_d;
         timeout_q   <= timeout_d;
         lock_meta_q <= lock_i;
         lock_s_q    <= lock_meta_q;
      end
   end

`ifdef PLL_SEQ_RETRY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retry_q <= 2'd0;
      else        retry_q <= retry_d;
   end
`endif

   assign cfg_valid_o = valid_q;
   assign cfg_data_o  = data_q;
   assign busy_o      = busy_q;
   assign locked_o    = locked_q;
   assign timeout_o   = timeout_q;
   assign state_o     = state_q;

endmodule
